// File: rtl/fila_bytes.sv
// Byte FIFO behind the serial-to-byte deserializer: one ack pulse per accepted byte, oldest-first pops.
// Define FILA_CLEAR_EN to add a synchronous clear_in; states: IDLE wait byte | ACK ack pulse | WAIT_LOW wait ready low.
module fila_bytes #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clock_100KHz,
  input  logic                         reset,
`ifdef FILA_CLEAR_EN
  input  logic                         clear_in,
`endif
  input  logic                         data_ready_in,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         ack_out,
  input  logic                         dequeue_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic [$clog2(DEPTH+1)-1:0]   len_out,
  output logic                         empty_out,
  output logic                         full_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en, clr;

`ifdef FILA_CLEAR_EN
  assign clr = clear_in;
`else
  assign clr = 1'b0;
`endif

  // Full is the registered flag, so a pop in the same cycle does not open space yet.
  assign wr_en = (state_q == IDLE) && data_ready_in && !full_q && !clr;
  assign rd_en = dequeue_in && !empty_q && !clr;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    dout_d   = dout_q;
    valid_d  = rd_en;

    case (state_q)
      IDLE:     if (wr_en) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
                end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!data_ready_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    case ({wr_en, rd_en})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase

    // Clear parks the FSM in WAIT_LOW so a byte still being offered is not written twice.
    if (clr) begin
      state_d  = WAIT_LOW;
      ack_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      len_d    = '0;
      valid_d  = 1'b0;
    end

    empty_d = (len_d == '0);
    full_d  = (len_d == LW'(DEPTH));
  end

  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clock_100KHz) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign ack_out    = ack_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign len_out    = len_q;
  assign empty_out  = empty_q;
  assign full_out   = full_q;

endmodule

// File: tb/tb_fila_bytes.sv
// Scoreboard bench for fila_bytes: random offers/pops against a queue-based reference model.
`timescale 1ns/1ps
module tb_fila_bytes;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clock_100KHz = 1'b0;
  logic             reset = 1'b1;
  logic             data_ready_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             dequeue_in = 1'b0;
  logic             ack_out, data_valid, empty_out, full_out;
  logic [WIDTH-1:0] data_out;
  logic [LW-1:0]    len_out;
`ifdef FILA_CLEAR_EN
  logic             clear_in = 1'b0;
`endif

  fila_bytes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
`ifdef FILA_CLEAR_EN
    .clear_in     (clear_in),
`endif
    .data_ready_in(data_ready_in),
    .data_in      (data_in),
    .ack_out      (ack_out),
    .dequeue_in   (dequeue_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .len_out      (len_out),
    .empty_out    (empty_out),
    .full_out     (full_out)
  );

  always #5000 clock_100KHz = ~clock_100KHz;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, occupancy as its size.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sbq[$];
  int               mlen = 0;
  bit               armed = 1'b1;
  int               since = 0;
  bit               exp_ack = 1'b0;
  bit               exp_valid = 1'b0;
  bit               accepted = 1'b0;
  logic [WIDTH-1:0] exp_dout = '0;

  always @(posedge clock_100KHz) begin
    if (!reset) begin
      bit w, p, c;
      c = 1'b0;
`ifdef FILA_CLEAR_EN
      c = clear_in;
`endif
      w = data_ready_in && (mq.size() < DEPTH) && armed && !c;
      p = dequeue_in && (mq.size() > 0) && !c;
      exp_valid = p;
      if (p) begin
        exp_dout = mq.pop_front();
        sbq.push_back(exp_dout);
      end
      if (c) begin
        mq.delete();
        armed = 1'b0;
        since = 2;
      end else if (w) begin
        mq.push_back(data_in);
        armed = 1'b0;
        since = 0;
      end else if (!armed) begin
        since++;
        if (since >= 2 && !data_ready_in) armed = 1'b1;
      end
      mlen     = mq.size();
      exp_ack  = w;
      accepted = w;
    end
  end

  always @(negedge clock_100KHz) begin
    if (!reset) begin
      chk("ack_out", int'(ack_out), int'(exp_ack));
      chk("len_out", int'(len_out), mlen);
      chk("empty_out", int'(empty_out), int'(mlen == 0));
      chk("full_out", int'(full_out), int'(mlen == DEPTH));
      chk("data_valid", int'(data_valid), int'(exp_valid));
      if (data_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got data_out %0h with nothing expected", data_out);
        end else begin
          chk("pop_data", int'(data_out), int'(sbq.pop_front()));
        end
      end else begin
        chk("data_out_hold", int'(data_out), int'(exp_dout));
      end
    end
  end

  bit offering = 1'b0;
  int gap = 0;

  task automatic step(input int p_offer, input int p_deq);
    @(negedge clock_100KHz);
    #1;
    if (offering && accepted) begin
      offering      = 1'b0;
      data_ready_in = 1'b0;
      gap           = 1 + $urandom_range(0, 2);
    end else if (!offering) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 99) < p_offer) begin
        offering      = 1'b1;
        data_ready_in = 1'b1;
        data_in       = WIDTH'($urandom_range(0, 255));
      end
    end
    dequeue_in = ($urandom_range(0, 99) < p_deq);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ack"}, int'(ack_out), 0);
    chk({tag, "_valid"}, int'(data_valid), 0);
    chk({tag, "_len"}, int'(len_out), 0);
    chk({tag, "_empty"}, int'(empty_out), 1);
    chk({tag, "_full"}, int'(full_out), 0);
    chk({tag, "_dout"}, int'(data_out), 0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clock_100KHz);
    check_reset_values("reset");
    #1 reset = 1'b0;

    repeat (300) step(90, 5);
    repeat (300) step(10, 90);
    repeat (600) step(60, 60);
    repeat (300) step(50, 100);

    // Empty out, then refill to 5 and hit reset while the ack pulse is high.
    repeat (30) step(0, 100);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(100, 0);
      if (mlen == 5 && exp_ack) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_len5_ack", int'(hit), 1);
    reset = 1'b1;
    mq.delete();
    sbq.delete();
    mlen = 0; armed = 1'b1; since = 0;
    exp_ack = 1'b0; exp_valid = 1'b0; accepted = 1'b0; exp_dout = '0;
    offering = 1'b0; gap = 0; data_ready_in = 1'b0; dequeue_in = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clock_100KHz);
    #1 reset = 1'b0;

`ifdef FILA_CLEAR_EN
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(100, 0);
      if (mlen == 4) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_len4", int'(hit), 1);
    offering = 1'b0; gap = 2; data_ready_in = 1'b0; dequeue_in = 1'b0;
    clear_in = 1'b1;
    @(negedge clock_100KHz);
    #1 clear_in = 1'b0;
    chk("clear_len", int'(len_out), 0);
`endif

    repeat (400) step(50, 50);
    repeat (40) step(0, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
